// File: rtl/acc_cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcode and FSM state encodings.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    NAND = 3'd1,
    SRRL = 3'd2,
    GE   = 3'd3,
    SZ   = 3'd4,
    CP2W = 3'd5,
    CPFW = 3'd6,
    JMP  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    IND   = 3'd1,
    OPER  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam int OP_W = 3;

  // CPfW skips the operand read and goes straight to the store.
  function automatic state_t operandState(opcode_t op);
    return (op == CPFW) ? WRITE : OPER;
  endfunction

endpackage

// File: rtl/acc_cpu_param_if.sv
// Memory port of the accumulator CPU: request/ready handshake with a single address/data bus.
interface acc_cpu_param_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              wrEn;
  logic [ADDR_W-1:0] addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic [DATA_W-1:0] data_fromRAM;
  logic              mem_ready;

  modport master (
    output mem_req, wrEn, addr_toRAM, data_toRAM,
    input  data_fromRAM, mem_ready
  );

  modport slave (
    input  mem_req, wrEn, addr_toRAM, data_toRAM,
    output data_fromRAM, mem_ready
  );
endinterface

// File: rtl/acc_cpu_shifter.sv
// Combinational SRRL unit: shift amount range selects right/left shift or right/left rotate.
module acc_cpu_shifter #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] sel,
  output logic [DATA_W-1:0] dout
);

  localparam logic [DATA_W-1:0] D1 = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] D2 = DATA_W'(2 * DATA_W);
  localparam logic [DATA_W-1:0] D3 = DATA_W'(3 * DATA_W);
  localparam logic [DATA_W-1:0] D4 = DATA_W'(4 * DATA_W);

  logic [2*DATA_W-1:0] dbl, rr, rl;
  logic [DATA_W-1:0]   k;

  // Rotates come from shifting the word concatenated with itself.
  always_comb begin
    dbl  = {din, din};
    k    = '0;
    rr   = '0;
    rl   = '0;
    dout = din;
    if (sel < D1) begin
      dout = din >> sel;
    end else if (sel < D2) begin
      k    = sel - D1;
      dout = din << k;
    end else if (sel < D3) begin
      k    = sel - D2;
      rr   = dbl >> k;
      dout = rr[DATA_W-1:0];
    end else if (sel < D4) begin
      k    = sel - D3;
      rl   = dbl << k;
      dout = rl[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised single-accumulator CPU with a req/ready memory port, halt-on-self-jump and retire pulse.
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int IND_PTR  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  acc_cpu_param_if.master   mem,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] W,
  output logic              retire,
  output logic              halted
);

  generate
    if (DATA_W != ADDR_W + OP_W) begin : gBadWidth
      $error("acc_cpu_param: DATA_W must equal ADDR_W+3");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] IND_ADDR = ADDR_W'(IND_PTR);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

  state_t            state, stateNxt;
  opcode_t           ir, irNxt;
  logic [ADDR_W-1:0] ea, eaNxt, pcNxt, addrMux;
  logic [DATA_W-1:0] m, mNxt, wNxt, shOut;
  logic              req, reqNxt, retireNxt, haltedNxt, done;
  opcode_t           fetchOp;
  logic [ADDR_W-1:0] fetchA;

  assign fetchOp = opcode_t'(mem.data_fromRAM[DATA_W-1:ADDR_W]);
  assign fetchA  = mem.data_fromRAM[ADDR_W-1:0];
  // Ready is only meaningful while a request is outstanding.
  assign done    = req && mem.mem_ready;

  acc_cpu_shifter #(.DATA_W(DATA_W)) uShift (
    .din  (W),
    .sel  (m),
    .dout (shOut)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      ir     <= ADD;
      ea     <= '0;
      m      <= '0;
      W      <= '0;
      PC     <= PC_RST;
      req    <= 1'b0;
      retire <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= stateNxt;
      ir     <= irNxt;
      ea     <= eaNxt;
      m      <= mNxt;
      W      <= wNxt;
      PC     <= pcNxt;
      req    <= reqNxt;
      retire <= retireNxt;
      halted <= haltedNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    irNxt     = ir;
    eaNxt     = ea;
    mNxt      = m;
    wNxt      = W;
    pcNxt     = PC;
    reqNxt    = req;
    retireNxt = 1'b0;
    haltedNxt = halted;
    case (state)
      FETCH: begin
        // First cycle out of reset has no request yet; raise it here.
        if (!req) begin
          reqNxt = 1'b1;
        end else if (done) begin
          irNxt = fetchOp;
          if (fetchA == '0) begin
            stateNxt = IND;
          end else begin
            eaNxt    = fetchA;
            stateNxt = operandState(fetchOp);
          end
        end
      end
      IND: begin
        if (done) begin
          eaNxt    = mem.data_fromRAM[ADDR_W-1:0];
          stateNxt = operandState(ir);
        end
      end
      OPER: begin
        if (done) begin
          mNxt     = mem.data_fromRAM;
          stateNxt = EXEC;
          reqNxt   = 1'b0;
        end
      end
      EXEC: begin
        retireNxt = 1'b1;
        pcNxt     = PC + ADDR_W'(1);
        case (ir)
          ADD:     wNxt = W + m;
          NAND:    wNxt = ~(W & m);
          SRRL:    wNxt = shOut;
          GE:      wNxt = (W >= m) ? DATA_W'(1) : '0;
          SZ:      pcNxt = PC + ((m == '0) ? ADDR_W'(2) : ADDR_W'(1));
          CP2W:    wNxt = m;
          JMP:     pcNxt = m[ADDR_W-1:0];
          default: ;
        endcase
        if (ir == JMP && m[ADDR_W-1:0] == PC) begin
          haltedNxt = 1'b1;
          stateNxt  = HALT;
        end else begin
          stateNxt = FETCH;
          reqNxt   = 1'b1;
        end
      end
      WRITE: begin
        if (done) begin
          pcNxt     = PC + ADDR_W'(1);
          retireNxt = 1'b1;
          stateNxt  = FETCH;
        end
      end
      HALT: reqNxt = 1'b0;
      default: begin
        stateNxt = FETCH;
        reqNxt   = 1'b0;
      end
    endcase
  end

  // Bus fields derive from registered state only, so they hold for the whole access.
  always_comb begin
    addrMux = '0;
    case (state)
      FETCH:       addrMux = PC;
      IND:         addrMux = IND_ADDR;
      OPER, WRITE: addrMux = ea;
      default:     addrMux = '0;
    endcase
  end

  assign mem.mem_req    = req;
  assign mem.addr_toRAM = req ? addrMux : '0;
  assign mem.wrEn       = req && (state == WRITE);
  assign mem.data_toRAM = (req && state == WRITE) ? W : '0;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: vector table, hand-written corner sequences, random programs vs ISA model.
module tb_acc_cpu_param;
  import acc_cpu_pkg::*;

  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int IP   = 2;
  localparam int MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] PC;
  logic [DW-1:0] W;
  logic          retire, halted;

  acc_cpu_param_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  acc_cpu_param #(.ADDR_W(AW), .DATA_W(DW), .IND_PTR(IP), .RESET_PC(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem    (bus.master),
    .PC     (PC),
    .W      (W),
    .retire (retire),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    bit            ind;
    logic [DW-1:0] w0;
    logic [DW-1:0] m;
    logic [DW-1:0] expW;
    logic [AW-1:0] expPC;
    int            expLat;
  } vec_t;

  vec_t          vecs [17];
  logic [DW-1:0] ram    [MEMN];
  logic [DW-1:0] refMem [MEMN];
  logic [DW-1:0] img    [MEMN];

  int checks = 0, failures = 0;
  int minWait = 0, maxWait = 0, waitsLeft = 0;
  int stabViol = 0, wrCount = 0;
  bit pending = 0;
  logic [AW-1:0] sAddr;
  logic          sWr;
  logic [DW-1:0] sData;

  logic [AW-1:0] rPC;
  logic [DW-1:0] rW;
  bit            rHalt;

  function automatic logic [DW-1:0] mk(input logic [2:0] op, input logic [AW-1:0] a);
    return {op, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock of RAM behaviour, evaluated at the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (bus.mem_req) begin
      if (pending) begin
        if (bus.addr_toRAM !== sAddr || bus.wrEn !== sWr || bus.data_toRAM !== sData) begin
          stabViol++;
          $display("FAIL stability addr=%h wr=%b data=%h held addr=%h wr=%b data=%h",
                   bus.addr_toRAM, bus.wrEn, bus.data_toRAM, sAddr, sWr, sData);
        end
      end else begin
        pending   = 1;
        waitsLeft = $urandom_range(maxWait, minWait);
        sAddr     = bus.addr_toRAM;
        sWr       = bus.wrEn;
        sData     = bus.data_toRAM;
      end
      if (waitsLeft == 0) begin
        bus.mem_ready    = 1'b1;
        bus.data_fromRAM = ram[bus.addr_toRAM];
        if (bus.wrEn) begin
          ram[bus.addr_toRAM] = bus.data_toRAM;
          wrCount++;
        end
        pending = 0;
      end else begin
        bus.mem_ready    = 1'b0;
        bus.data_fromRAM = DW'($urandom);
        waitsLeft--;
      end
    end else begin
      pending          = 0;
      bus.mem_ready    = 1'($urandom_range(0, 1));
      bus.data_fromRAM = DW'($urandom);
    end
  endtask

  task automatic runRetire(output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!retire && lat < 300);
    if (!retire) begin
      checks++;
      failures++;
      $display("FAIL retire_timeout cycles=%0d required=retire pulse", lat);
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic clearRam();
    for (int i = 0; i < MEMN; i++) ram[i] = '0;
  endtask

  // Instruction-level reference: one whole instruction per call.
  task automatic refStep();
    logic [DW-1:0] ins, mv;
    logic [AW-1:0] a, ea;
    opcode_t       op;
    int            s, k;
    ins = refMem[rPC];
    op  = opcode_t'(ins[DW-1:AW]);
    a   = ins[AW-1:0];
    ea  = (a == 0) ? refMem[IP][AW-1:0] : a;
    mv  = refMem[ea];
    s   = int'(mv);
    case (op)
      ADD:  rW = rW + mv;
      NAND: rW = ~(rW & mv);
      SRRL: begin
        if (s < DW)            rW = rW >> s;
        else if (s < 2 * DW)   rW = rW << (s - DW);
        else if (s < 3 * DW) begin k = s - 2 * DW; rW = (rW >> k) | (rW << (DW - k)); end
        else if (s < 4 * DW) begin k = s - 3 * DW; rW = (rW << k) | (rW >> (DW - k)); end
      end
      GE:   rW = (rW >= mv) ? DW'(1) : DW'(0);
      CP2W: rW = mv;
      CPFW: refMem[ea] = rW;
      default: ;
    endcase
    if (op == SZ)       rPC = rPC + ((mv == 0) ? AW'(2) : AW'(1));
    else if (op == JMP) begin
      if (mv[AW-1:0] == rPC) rHalt = 1;
      rPC = mv[AW-1:0];
    end else            rPC = rPC + AW'(1);
  endtask

  task automatic runRandom(input int mw, input int nInstr);
    int lat, diff;
    for (int i = 0; i < MEMN; i++) begin
      ram[i]    = img[i];
      refMem[i] = img[i];
    end
    minWait = 0;
    maxWait = mw;
    rPC = '0; rW = '0; rHalt = 0;
    doReset();
    for (int n = 0; n < nInstr && !rHalt; n++) begin
      runRetire(lat);
      refStep();
      chk($sformatf("rand_w%0d_pc", mw), 32'(PC), 32'(rPC));
      chk($sformatf("rand_w%0d_w", mw), 32'(W), 32'(rW));
    end
    chk($sformatf("rand_w%0d_halted", mw), 32'(halted), 32'(rHalt));
    diff = 0;
    for (int i = 0; i < MEMN; i++) if (ram[i] !== refMem[i]) diff++;
    chk($sformatf("rand_w%0d_memdiff", mw), 32'(diff), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, bad, r;
    bus.mem_ready    = 1'b0;
    bus.data_fromRAM = '0;
    vecs = '{
      '{ADD,  1'b0, 16'd16,   16'd16,   16'd32,   13'd2,     3},
      '{NAND, 1'b0, 16'hFFFF, 16'h00F0, 16'hFF0F, 13'd2,     3},
      '{SRRL, 1'b0, 16'h0100, 16'd5,    16'h0008, 13'd2,     3},
      '{SRRL, 1'b0, 16'h0010, 16'd19,   16'h0080, 13'd2,     3},
      '{SRRL, 1'b0, 16'h0FDE, 16'd36,   16'hE0FD, 13'd2,     3},
      '{SRRL, 1'b0, 16'h0100, 16'd64,   16'h0100, 13'd2,     3},
      '{SRRL, 1'b0, 16'h8001, 16'd49,   16'h0003, 13'd2,     3},
      '{SRRL, 1'b0, 16'h8000, 16'd15,   16'h0001, 13'd2,     3},
      '{GE,   1'b0, 16'd5,    16'd5,    16'd1,    13'd2,     3},
      '{GE,   1'b0, 16'd4,    16'd5,    16'd0,    13'd2,     3},
      '{SZ,   1'b0, 16'd7,    16'd0,    16'd7,    13'd3,     3},
      '{SZ,   1'b0, 16'd7,    16'd1,    16'd7,    13'd2,     3},
      '{CP2W, 1'b0, 16'd0,    16'h1234, 16'h1234, 13'd2,     3},
      '{JMP,  1'b0, 16'd0,    16'hE100, 16'd0,    13'h0100,  3},
      '{ADD,  1'b1, 16'hFFFF, 16'd2,    16'h0001, 13'd2,     4},
      '{CPFW, 1'b0, 16'hBEEF, 16'd0,    16'hBEEF, 13'd2,     2},
      '{CPFW, 1'b1, 16'hDEAF, 16'd0,    16'hDEAF, 13'd2,     3}
    };

    cyc();
    cyc();
    chk("reset_ctl", {28'd0, bus.mem_req, bus.wrEn, retire, halted}, 32'd0);
    chk("reset_pc", 32'(PC), 32'd0);
    chk("reset_w", 32'(W), 32'd0);
    chk("reset_bus", {3'd0, bus.addr_toRAM, bus.data_toRAM}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      clearRam();
      ram[0]  = mk(CP2W, 13'd10);
      ram[10] = vecs[i].w0;
      ram[1]  = mk(vecs[i].op, vecs[i].ind ? 13'd0 : 13'd11);
      ram[11] = vecs[i].m;
      ram[IP] = 16'd11;
      minWait = 0;
      maxWait = 0;
      doReset();
      runRetire(lat);
      runRetire(lat);
      chk($sformatf("vec%0d_w", i), 32'(W), 32'(vecs[i].expW));
      chk($sformatf("vec%0d_pc", i), 32'(PC), 32'(vecs[i].expPC));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].expLat));
      if (vecs[i].op == CPFW) chk($sformatf("vec%0d_mem", i), 32'(ram[11]), 32'(vecs[i].w0));
    end

    // Indirect jump through the pointer word.
    clearRam();
    ram[0] = 16'hE000;
    ram[IP] = 16'd3;
    ram[3] = 16'd3;
    doReset();
    runRetire(lat);
    chk("ind_jmp_pc", 32'(PC), 32'd3);

    // Indirect store: exactly one write handshake, at the pointed-to address.
    clearRam();
    ram[0]  = mk(CP2W, 13'd10);
    ram[10] = 16'hDEAF;
    ram[1]  = mk(CPFW, 13'd0);
    ram[IP] = 16'd147;
    doReset();
    runRetire(lat);
    base = wrCount;
    runRetire(lat);
    chk("ind_cpfw_mem", 32'(ram[147]), 32'h0000DEAF);
    chk("ind_cpfw_writes", 32'(wrCount - base), 32'd1);
    chk("ind_cpfw_lat", 32'(lat), 32'd3);

    // Self-jump halts, then an asynchronous reset clears everything.
    clearRam();
    ram[0]   = mk(CP2W, 13'd7);
    ram[7]   = 16'h0055;
    ram[1]   = mk(JMP, 13'd5);
    ram[5]   = 16'd158;
    ram[158] = mk(JMP, 13'd6);
    ram[6]   = 16'd158;
    doReset();
    runRetire(lat);
    runRetire(lat);
    chk("jmp_pc", 32'(PC), 32'd158);
    chk("jmp_not_halted", 32'(halted), 32'd0);
    runRetire(lat);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(PC), 32'd158);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.mem_req || retire || !halted || PC != 13'd158) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pc", 32'(PC), 32'd0);
    chk("async_rst_w", 32'(W), 32'd0);
    chk("async_rst_halted", 32'(halted), 32'd0);
    cyc();
    rst = 1'b1;

    // Reset in the middle of a stalled fetch: request drops, CPU restarts at PC 0.
    minWait = 4;
    maxWait = 4;
    doReset();
    cyc();
    cyc();
    chk("midacc_req_before", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midacc_req_dropped", 32'(bus.mem_req), 32'd0);
    cyc();
    rst = 1'b1;
    minWait = 0;
    maxWait = 0;
    runRetire(lat);
    chk("midacc_restart_pc", 32'(PC), 32'd1);
    chk("midacc_restart_w", 32'(W), 32'h55);

    for (int i = 0; i < MEMN; i++) begin
      r = $urandom_range(0, 7);
      if (r < 2)       img[i] = DW'($urandom_range(0, 79));
      else if (r == 2) img[i] = {3'($urandom_range(0, 7)), 13'd0};
      else             img[i] = DW'($urandom);
    end
    runRandom(0, 300);
    runRandom(4, 300);
    chk("bus_stability", 32'(stabViol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised successor of the 2021 single-accumulator CPU (W register, 3-bit opcode, direct or indirect operand).
- Generalised in data/address width and in the indirect pointer location.
- Adds a variable-latency memory handshake (req/ready), a halt-on-self-jump detector and a retire pulse for benches.
- Sits between a block RAM (or a RAM wrapper that generates ready) and the top level; exports PC and W for checking.

Parameters:
- ADDR_W, 13, address/PC width.
- DATA_W, 16, data/W width; must equal ADDR_W+3 (elaboration-time error otherwise).
- IND_PTR, 2, memory location holding the pointer used for indirect operands.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request.
- wrEn  out  1  write qualifier, valid while mem_req is high.
- addr_toRAM  out  ADDR_W  access address.
- data_toRAM  out  DATA_W  write data.
- data_fromRAM  in  DATA_W  read data, valid in the cycle mem_ready is high.
- mem_ready  in  1  access completes at this clock edge.
- PC  out  ADDR_W  program counter.
- W  out  DATA_W  accumulator.
- retire  out  1  one-cycle pulse when an instruction commits.
- halted  out  1  sticky; high after a self-jump.

Behaviour:
- Reset (rst low, async): PC=RESET_PC, W=0, state FETCH; mem_req, wrEn, retire and halted all 0; addr_toRAM and data_toRAM 0.
- Instruction format: opcode = bits [DATA_W-1:ADDR_W], A = [ADDR_W-1:0].
- A==0 selects indirect: effective address EA = mem[IND_PTR][ADDR_W-1:0]. Otherwise EA=A.
- Handshake:
  - Once mem_req is raised, addr_toRAM, wrEn and data_toRAM hold stable until an edge where mem_ready=1.
  - Zero-wait completion (ready high in the first req cycle) is legal.
  - mem_ready while mem_req=0 is ignored.
- States:
  - FETCH: req at PC; on ready, latch IR, then go to IND if A==0, else OPER (or WRITE for CPfW).
  - IND: req at IND_PTR; on ready, latch EA, then go to OPER (WRITE for CPfW).
  - OPER: req read at EA; on ready, latch operand M, then go to EXEC.
  - EXEC: single cycle, no req; updates W/PC, pulses retire, then returns to FETCH (or HALT).
  - WRITE: req with wrEn=1 at EA, data_toRAM=W; on ready, PC+1, pulse retire, return to FETCH.
  - HALT: absorbing; no req; only reset exits.
- Opcodes (M = operand, unsigned):
  - 0 ADD: W=W+M modulo 2^DATA_W.
  - 1 NAND: W=~(W&M).
  - 2 SRRL, shift/rotate selected by s=M:
    - s<DATA_W: logical right shift by s.
    - s<2·DATA_W: logical left shift by s−DATA_W.
    - s<3·DATA_W: rotate right by s−2·DATA_W.
    - s<4·DATA_W: rotate left by s−3·DATA_W.
    - otherwise W unchanged.
  - 3 GE: W = (W>=M) ? 1 : 0.
  - 4 SZ: PC += (M==0) ? 2 : 1.
  - 5 CP2W: W=M.
  - 6 CPfW: mem[EA]=W.
  - 7 JMP: PC=M[ADDR_W-1:0].
- PC update: all opcodes except SZ and JMP set PC=PC+1. All PC arithmetic wraps modulo 2^ADDR_W.
- Halt: JMP whose target equals the current PC sets halted=1 in EXEC; that instruction still retires; next state HALT.
- Latency at zero-wait ready:
  - direct ALU/SZ/JMP: 3 cycles.
  - indirect: +1 cycle.
  - CPfW: 2 cycles direct, 3 cycles indirect.
  - Each wait cycle adds 1.
- Boundaries:
  - Reset asserted mid-access drops mem_req immediately.
  - No access is retried after reset; the CPU restarts at RESET_PC.
  - An indirect pointer value of 0 is legal and used as EA=0.
  - IR and EA never change while mem_req is high.

Decomposition:
- Shared package acc_cpu_pkg: opcode enum (ADD, NAND, SRRL, GE, SZ, CP2W, CPFW, JMP) and state enum (FETCH, IND, OPER, EXEC, WRITE, HALT).
- One sub-module acc_cpu_shifter: combinational SRRL unit, parametrised on DATA_W.

Test Plan:
- Reset, zero-wait RAM with mem[0]=JMP 0 (opcode 7, A=0) and mem[IND_PTR=2]=3 (indirect) → PC=3 after the first retire.
- Direct ADD, W=16, operand 16 → W=32; then NAND with W=0xFFFF and operand 0x00F0 → W=0xFF0F; retire pulses exactly once per instruction.
- SRRL, W=0x0100: s=5 → 0x0008; s=16+3 (from 0x0010) → 0x0080; s=32+4 on 0x0FDE → 0xE0FD; s=64 → W unchanged.
- Random 0–4 wait states on mem_ready → results identical to the zero-wait run; addr/wrEn/data stable while mem_req is high.
- Indirect CPfW with W=0xDEAF and mem[2]=147 → mem[147]=0xDEAF; wrEn high for exactly one handshake.
- Self-jump at PC=158 → halted=1, PC holds 158, mem_req stays 0; async rst low then high → PC=0, W=0, halted=0.
